// File: rtl/pea_pkg.sv
// Shared types and configuration-width helpers for the PEA processing elements.
package pea_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB,
        OP_MUL,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_MAX,
        OP_ACC,
        OP_NOP
    } pe_op_t;

    typedef enum logic {
        ACC_IDLE,
        ACC_RUN
    } acc_state_t;

    function automatic int log_sel(input int n_neigh);
        return $clog2(n_neigh + 3);
    endfunction

    function automatic int log_rf(input int rf_depth);
        return $clog2(rf_depth);
    endfunction

    function automatic int cfg_w(input int n_neigh, input int rf_depth);
        return 2 * log_sel(n_neigh) + 5 + 2 * log_rf(rf_depth);
    endfunction

endpackage

// File: rtl/pe_out_fifo.sv
// Pointer-based output queue; DEPTH must be a power of two so the pointers wrap naturally.
module pe_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [AW:0]                 count_q;
    logic                        do_push;
    logic                        do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    // Head reads as zero when empty so the output is clean out of reset without resetting storage.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_elastic.sv
// Elastic PEA processing element: operand select, ALU, length-bounded ACC FSM, output queue.
// Build option: define PE_SAT_EN for signed saturation on ADD/SUB/ACC (default wraps).
module pe_elastic
    import pea_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_NEIGH    = 4,
    parameter int RF_DEPTH   = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [cfg_w(N_NEIGH, RF_DEPTH)-1:0]  ctrl_i,
    input  logic                                 flush_i,
    input  logic [7:0]                           acc_len_i,
    input  logic [N_NEIGH-1:0][N_BITS-1:0]       neigh_op_i,
    input  logic [N_NEIGH-1:0]                   neigh_valid_i,
    output logic [N_NEIGH-1:0]                   neigh_ready_o,
    output logic [N_BITS-1:0]                    res_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_cnt_o,
    output logic                                 busy_o
);

    localparam int LOG_SEL = log_sel(N_NEIGH);
    localparam int LOG_RF  = log_rf(RF_DEPTH);
    localparam int SH_W    = $clog2(N_BITS);
    localparam int OP_LSB  = 2 * LOG_SEL;

    logic [LOG_SEL-1:0] sel_a, sel_b;
    logic [3:0]         op_raw;
    pe_op_t             op;
    logic               op_act, rf_we;
    logic [LOG_RF-1:0]  rf_waddr, rf_raddr;

    assign sel_a    = ctrl_i[LOG_SEL-1:0];
    assign sel_b    = ctrl_i[OP_LSB-1:LOG_SEL];
    assign op_raw   = ctrl_i[OP_LSB+3:OP_LSB];
    assign op       = pe_op_t'(op_raw);
    assign rf_we    = ctrl_i[OP_LSB+4];
    assign rf_waddr = ctrl_i[OP_LSB+5 +: LOG_RF];
    assign rf_raddr = ctrl_i[OP_LSB+5+LOG_RF +: LOG_RF];
    // Codes above ACC (NOP and unused encodings) never fire.
    assign op_act   = (op_raw <= 4'(OP_ACC));

    logic [RF_DEPTH-1:0][N_BITS-1:0] rf_q;
    logic [N_BITS-1:0]  last_res_q, acc_q;
    logic [7:0]         count_q, len_q;
    acc_state_t         acc_state_q;

    logic [N_BITS-1:0]  op_a, op_b, alu_res, acc_sum, acc_push_val, push_data;
    logic               op_a_valid, op_b_valid, fire, push, acc_done;
    logic [7:0]         acc_len_eff;
    logic               fifo_full, fifo_empty;

    function automatic logic [N_BITS-1:0] add_op(input logic [N_BITS-1:0] x, input logic [N_BITS-1:0] y);
`ifdef PE_SAT_EN
        logic [N_BITS:0] s;
        s = {x[N_BITS-1], x} + {y[N_BITS-1], y};
        if (s[N_BITS] != s[N_BITS-1])
            return s[N_BITS] ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
        return s[N_BITS-1:0];
`else
        return x + y;
`endif
    endfunction

    function automatic logic [N_BITS-1:0] sub_op(input logic [N_BITS-1:0] x, input logic [N_BITS-1:0] y);
`ifdef PE_SAT_EN
        logic [N_BITS:0] s;
        s = {x[N_BITS-1], x} - {y[N_BITS-1], y};
        if (s[N_BITS] != s[N_BITS-1])
            return s[N_BITS] ? {1'b1, {(N_BITS-1){1'b0}}} : {1'b0, {(N_BITS-1){1'b1}}};
        return s[N_BITS-1:0];
`else
        return x - y;
`endif
    endfunction

    // SELF and RF sources are always valid; ZERO covers its own code and every code above it.
    always_comb begin
        op_a = '0;
        op_b = '0;
        op_a_valid = 1'b1;
        op_b_valid = 1'b1;
        if (sel_a == LOG_SEL'(N_NEIGH))   op_a = last_res_q;
        if (sel_a == LOG_SEL'(N_NEIGH+1)) op_a = rf_q[rf_raddr];
        if (sel_b == LOG_SEL'(N_NEIGH))   op_b = last_res_q;
        if (sel_b == LOG_SEL'(N_NEIGH+1)) op_b = rf_q[rf_raddr];
        for (int i = 0; i < N_NEIGH; i++) begin
            if (sel_a == LOG_SEL'(i)) begin
                op_a = neigh_op_i[i];
                op_a_valid = neigh_valid_i[i];
            end
            if (sel_b == LOG_SEL'(i)) begin
                op_b = neigh_op_i[i];
                op_b_valid = neigh_valid_i[i];
            end
        end
    end

    // Handshake: upstream operands are consumed on the edge where fire is high, and neigh_ready_o
    // strobes for exactly those sources; fire depends only on registered full, never on ready_i.
    // Downstream transfer happens on any edge with valid_o & ready_i.
    assign fire = op_a_valid & op_b_valid & ~fifo_full & op_act & ~flush_i;

    always_comb begin
        neigh_ready_o = '0;
        for (int i = 0; i < N_NEIGH; i++)
            neigh_ready_o[i] = fire & ((sel_a == LOG_SEL'(i)) | (sel_b == LOG_SEL'(i)));
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = add_op(op_a, op_b);
            OP_SUB:  alu_res = sub_op(op_a, op_b);
            OP_MUL:  alu_res = op_a * op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << op_b[SH_W-1:0];
            OP_SRL:  alu_res = op_a >> op_b[SH_W-1:0];
            OP_MAX:  alu_res = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        acc_len_eff  = (acc_len_i == 8'd0) ? 8'd1 : acc_len_i;
        acc_sum      = add_op(acc_q, op_b);
        acc_done     = 1'b0;
        acc_push_val = '0;
        if (fire && op == OP_ACC) begin
            if (acc_state_q == ACC_IDLE) begin
                acc_done     = (acc_len_eff == 8'd1);
                acc_push_val = op_b;
            end else begin
                acc_done     = (count_q == len_q - 8'd1);
                acc_push_val = acc_sum;
            end
        end
    end

    assign push      = fire & ((op != OP_ACC) | acc_done);
    assign push_data = (op == OP_ACC) ? acc_push_val : alu_res;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_state_q <= ACC_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            last_res_q  <= '0;
        end else if (flush_i) begin
            acc_state_q <= ACC_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            last_res_q  <= '0;
        end else begin
            if (push) last_res_q <= push_data;
            if (fire && op == OP_ACC) begin
                case (acc_state_q)
                    ACC_IDLE: begin
                        len_q <= acc_len_eff;
                        if (acc_done) begin
                            acc_q   <= '0;
                            count_q <= '0;
                        end else begin
                            acc_q       <= op_b;
                            count_q     <= 8'd1;
                            acc_state_q <= ACC_RUN;
                        end
                    end
                    default: begin
                        if (acc_done) begin
                            acc_q       <= '0;
                            count_q     <= '0;
                            acc_state_q <= ACC_IDLE;
                        end else begin
                            acc_q   <= acc_sum;
                            count_q <= count_q + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Register file survives flush; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            rf_q <= '0;
        else if (push && rf_we)
            rf_q[rf_waddr] <= push_data;
    end

    pe_out_fifo #(
        .WIDTH (N_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (ready_i),
        .data_o  (res_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_o)
    );

    assign valid_o = ~fifo_empty;
    assign busy_o  = (acc_state_q == ACC_RUN) | ~fifo_empty;

endmodule

// File: tb/tb_pe_elastic.sv
// Bench for pe_elastic at N_BITS=8: vector table, hand-written corner sequences, output scoreboard.
module tb_pe_elastic;
    import pea_pkg::*;

    localparam int N_BITS = 8, N_NEIGH = 4, RF_DEPTH = 4, FIFO_DEPTH = 2;
    localparam int CFG_W = cfg_w(N_NEIGH, RF_DEPTH);
    localparam logic [2:0] S_N0 = 3'd0, S_N1 = 3'd1, S_N2 = 3'd2, S_SELF = 3'd4,
                           S_RF = 3'd5, S_ZERO = 3'd6, S_HI = 3'd7;

    logic                           clk, rst_n, flush, ready, valid, busy;
    logic [CFG_W-1:0]               ctrl;
    logic [7:0]                     acc_len;
    logic [N_NEIGH-1:0][N_BITS-1:0] neigh_op;
    logic [N_NEIGH-1:0]             neigh_valid, neigh_ready;
    logic [N_BITS-1:0]              res;
    logic [1:0]                     fifo_cnt;

    pe_elastic #(
        .N_BITS(N_BITS), .N_NEIGH(N_NEIGH), .RF_DEPTH(RF_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .ctrl_i(ctrl), .flush_i(flush), .acc_len_i(acc_len),
        .neigh_op_i(neigh_op), .neigh_valid_i(neigh_valid), .neigh_ready_o(neigh_ready),
        .res_o(res), .valid_o(valid), .ready_i(ready), .fifo_cnt_o(fifo_cnt), .busy_o(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests_run = 0;
    int tests_failed = 0;
    logic [N_BITS-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk_ctrl(input logic [2:0] sa, input logic [2:0] sb,
            input logic [3:0] op, input logic we, input logic [1:0] wa, input logic [1:0] ra);
        return {ra, wa, we, op, sb, sa};
    endfunction

    function automatic logic [7:0] model_add(input logic [7:0] x, input logic [7:0] y);
        int s;
        s = int'($signed(x)) + int'($signed(y));
`ifdef PE_SAT_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", res);
            end else begin
                check("res_o", res, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] sa, input logic [2:0] sb, input logic [3:0] op,
            input logic we, input logic [1:0] wa, input logic [1:0] ra,
            input logic [7:0] a, input logic [7:0] b);
        ctrl = mk_ctrl(sa, sb, op, we, wa, ra);
        neigh_op[0] = a;
        neigh_op[1] = b;
        neigh_valid = 4'b0011;
    endtask

    // Waits until the queue has room (the op then fires), records the expected push, then idles.
    task automatic wait_fire(input string name, input bit do_push, input logic [7:0] exp,
            input logic [3:0] mask);
        bit fired = 0;
        int cyc = 0;
        while (!fired && cyc < 40) begin
            @(negedge clk);
            if (fifo_cnt != 2'(FIFO_DEPTH)) begin
                check({name, "_nready"}, neigh_ready, mask);
                if (do_push) exp_q.push_back(exp);
                fired = 1;
            end else begin
                check({name, "_stall_nready"}, neigh_ready, 4'b0000);
                tick();
                if (cyc >= 2) ready = 1'b1;
            end
            cyc++;
        end
        if (!fired) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: got no fire, expected fire within 40 cycles", name);
        end
        tick();
        ctrl = mk_ctrl(S_N0, S_N0, OP_NOP, 1'b0, 2'd0, 2'd0);
        neigh_valid = '0;
    endtask

    task automatic drain();
        int cyc = 0;
        ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] ra, rb, rexp;
        logic [3:0] rop;

        vecs[0]  = '{"add",       OP_ADD, 8'd5,   8'd7,   8'd12};
        vecs[1]  = '{"sub_neg",   OP_SUB, 8'd3,   8'd5,   8'hFE};
        vecs[2]  = '{"mul_low",   OP_MUL, 8'd20,  8'd13,  8'h04};
        vecs[3]  = '{"and",       OP_AND, 8'hF0,  8'h3C,  8'h30};
        vecs[4]  = '{"or",        OP_OR,  8'hF0,  8'h3C,  8'hFC};
        vecs[5]  = '{"xor",       OP_XOR, 8'hF0,  8'h3C,  8'hCC};
        vecs[6]  = '{"sll_mask",  OP_SLL, 8'h81,  8'h0B,  8'h08};
        vecs[7]  = '{"srl_mask",  OP_SRL, 8'h80,  8'h0A,  8'h20};
        vecs[8]  = '{"max_pos",   OP_MAX, 8'h7F,  8'h80,  8'h7F};
        vecs[9]  = '{"max_neg",   OP_MAX, 8'hFE,  8'h02,  8'h02};
`ifdef PE_SAT_EN
        vecs[10] = '{"add_ovf",   OP_ADD, 8'd100, 8'd100, 8'h7F};
        vecs[11] = '{"sub_ovf",   OP_SUB, 8'h80,  8'd1,   8'h80};
`else
        vecs[10] = '{"add_ovf",   OP_ADD, 8'd100, 8'd100, 8'hC8};
        vecs[11] = '{"sub_ovf",   OP_SUB, 8'h80,  8'd1,   8'h7F};
`endif

        rst_n = 1'b0;
        flush = 1'b0;
        ready = 1'b0;
        acc_len = 8'd0;
        neigh_op = '0;
        neigh_valid = '0;
        ctrl = mk_ctrl(S_N0, S_N0, OP_NOP, 1'b0, 2'd0, 2'd0);
        #12;
        check("rst_valid", valid, 0);
        check("rst_res", res, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single ADD: output valid one cycle after fire.
        ready = 1'b1;
        drive_op(S_N0, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd5, 8'd7);
        wait_fire("add_first", 1'b1, 8'd12, 4'b0011);
        @(negedge clk);
        check("add_latency_valid", valid, 1);
        tick();

        for (int i = 0; i < 12; i++) begin
            drive_op(S_N0, S_N1, vecs[i].op, 1'b0, 2'd0, 2'd0, vecs[i].a, vecs[i].b);
            wait_fire(vecs[i].name, 1'b1, vecs[i].exp, 4'b0011);
        end
        drain();

        // Backpressure: two pushes fill the queue, third stalls until a pop.
        ready = 1'b0;
        drive_op(S_N0, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd1, 8'd2);
        wait_fire("bp_1", 1'b1, 8'd3, 4'b0011);
        drive_op(S_N0, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd4, 8'd5);
        wait_fire("bp_2", 1'b1, 8'd9, 4'b0011);
        drive_op(S_N0, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd10, 8'd20);
        repeat (3) begin
            @(negedge clk);
            check("bp_full_nready", neigh_ready, 4'b0000);
            check("bp_full_cnt", fifo_cnt, 2);
        end
        tick();
        ready = 1'b1;
        wait_fire("bp_3", 1'b1, 8'd30, 4'b0011);
        drain();

        // Register file write/read, SELF, high select code, neighbour valid gating.
        drive_op(S_N0, S_N1, OP_ADD, 1'b1, 2'd2, 2'd0, 8'd3, 8'd4);
        wait_fire("rf_write", 1'b1, 8'd7, 4'b0011);
        drive_op(S_RF, S_ZERO, OP_ADD, 1'b0, 2'd0, 2'd2, 8'd0, 8'd0);
        wait_fire("rf_read", 1'b1, 8'd7, 4'b0000);
        drive_op(S_SELF, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd0, 8'd9);
        wait_fire("self", 1'b1, 8'd16, 4'b0010);
        drive_op(S_HI, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd0, 8'h33);
        wait_fire("sel_hi_zero", 1'b1, 8'h33, 4'b0010);
        drain();
        drive_op(S_N2, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd0, 8'd1);
        neigh_op[2] = 8'h40;
        repeat (2) begin
            @(negedge clk);
            check("invalid_src_nready", neigh_ready, 4'b0000);
            check("invalid_src_cnt", fifo_cnt, 0);
        end
        tick();
        neigh_valid[2] = 1'b1;
        wait_fire("valid_src", 1'b1, 8'h41, 4'b0110);
        drain();

        // ACC of four operands; acc_len_i change mid-run must be ignored.
        acc_len = 8'd4;
        for (int k = 0; k < 4; k++) begin
            drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'(k + 1));
            wait_fire("acc4", k == 3, 8'd10, 4'b0011);
            if (k == 0) acc_len = 8'd1;
            if (k < 3) begin
                @(negedge clk);
                check("acc4_no_push", fifo_cnt, 0);
                check("acc4_busy", busy, 1);
                tick();
            end
        end
        drain();

        // acc_len_i = 0 behaves as 1: every operand pushed.
        acc_len = 8'd0;
        for (int k = 0; k < 3; k++) begin
            drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'(9 - k));
            wait_fire("acc_len0", 1'b1, 8'(9 - k), 4'b0011);
        end
        drain();

        // Flush mid-ACC with one queued result.
        ready = 1'b0;
        drive_op(S_N0, S_N1, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd1, 8'd1);
        wait_fire("flush_pre_add", 1'b1, 8'd2, 4'b0011);
        acc_len = 8'd4;
        drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'd5);
        wait_fire("flush_acc_1", 1'b0, 8'd0, 4'b0011);
        drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'd6);
        wait_fire("flush_acc_2", 1'b0, 8'd0, 4'b0011);
        @(negedge clk);
        check("preflush_cnt", fifo_cnt, 1);
        check("preflush_busy", busy, 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_cnt", fifo_cnt, 0);
        check("flush_busy", busy, 0);
        check("flush_valid", valid, 0);
        tick();
        ready = 1'b1;
        drive_op(S_SELF, S_ZERO, OP_ADD, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0);
        wait_fire("flush_last_res", 1'b1, 8'd0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'd1);
            wait_fire("flush_acc_restart", k == 3, 8'd4, 4'b0011);
        end
        drain();

        // Asynchronous reset in the middle of an ACC run.
        acc_len = 8'd2;
        drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'd3);
        wait_fire("rst_acc_1", 1'b0, 8'd0, 4'b0011);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_cnt", fifo_cnt, 0);
        tick();
        rst_n = 1'b1;
        drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'd3);
        wait_fire("rst_acc_a", 1'b0, 8'd0, 4'b0011);
        drive_op(S_N0, S_N1, OP_ACC, 1'b0, 2'd0, 2'd0, 8'd0, 8'd4);
        wait_fire("rst_acc_b", 1'b1, 8'd7, 4'b0011);
        drain();

        // Random traffic with random downstream stalls.
        for (int k = 0; k < 16; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: begin rop = OP_ADD; rexp = model_add(ra, rb); end
                1: begin rop = OP_XOR; rexp = ra ^ rb; end
                default: begin rop = OP_AND; rexp = ra & rb; end
            endcase
            ready = 1'($urandom_range(0, 1));
            drive_op(S_N0, S_N1, rop, 1'b0, 2'd0, 2'd0, ra, rb);
            wait_fire("rand", 1'b1, rexp, 4'b0011);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
